fetch_unit: RTL

Parametrised, decoupled instruction-fetch stage for the MIPS core. It replaces direct combinational indexing of instruction memory with a request/response port that tolerates variable memory latency. It owns the PC and a small queue of fetched instructions, and hands instructions to decode over a valid/ready handshake. Branch/jump redirects from later stages flush the queue and discard in-flight stale responses.

---
 rtl/fetch_unit_pkg.sv | 8 +
 rtl/fetch_queue.sv | 55 +++++
 rtl/fetch_unit.sv | 62 ++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared instruction/address width defaults and pointer sizing for the fetch stage
package fetch_unit_pkg;
   localparam int INSTR_W_DEF = 32;
   localparam int ADDR_W_DEF = 10;
   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular buffer; ports reserve/fill/pop/flush in, head entry and reserved-slot count out
module fetch_queue import fetch_unit_pkg::*; #(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int INSTR_W = INSTR_W_DEF,
   parameter int DEPTH = 4,
   localparam int PW = ptr_w(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               reserve,
   input  logic [ADDR_W-1:0]  reserve_pc,
   input  logic               fill,
   input  logic [INSTR_W-1:0] fill_data,
   input  logic               pop,
   input  logic               flush,
   output logic               head_valid,
   output logic [INSTR_W-1:0] head_instr,
   output logic [ADDR_W-1:0]  head_pc,
   output logic [CW-1:0]      count
);
   logic [ADDR_W-1:0] pc_q [DEPTH];
   logic [INSTR_W-1:0] instr_q [DEPTH];
   logic [DEPTH-1:0] filled;
   logic [PW-1:0] head, tail, fptr;
   assign head_valid = filled[head];
   assign head_instr = instr_q[head];
   assign head_pc = pc_q[head];
   always_ff @(posedge clk or posedge rst)
      if (rst || flush) begin
         filled <= '0;
         head <= '0;
         tail <= '0;
         fptr <= '0;
         count <= '0;
      end else begin
         if (reserve) begin
            filled[tail] <= 1'b0;
            tail <= tail + PW'(1);
         end
         if (fill) begin
            filled[fptr] <= 1'b1;
            fptr <= fptr + PW'(1);
         end
         if (pop) begin
            filled[head] <= 1'b0;
            head <= head + PW'(1);
         end
         count <= count + CW'(reserve) - CW'(pop);
      end
   always_ff @(posedge clk) begin
      if (reserve) pc_q[tail] <= reserve_pc;
      if (fill) instr_q[fptr] <= fill_data;
   end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: decoupled fetch stage; ports imem req/rsp, redirect in, decode valid/ready out, occupancy
module fetch_unit import fetch_unit_pkg::*; #(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int INSTR_W = INSTR_W_DEF,
   parameter int DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
   localparam int CW = ptr_w(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req_valid,
   output logic [ADDR_W-1:0]  imem_req_addr,
   input  logic               imem_req_ready,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_addr,
   output logic               out_valid,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc,
   input  logic               out_ready,
   output logic [CW-1:0]      occupancy
);
   logic [ADDR_W-1:0] pc;
   logic [CW-1:0] count, drop, pend;
   logic accept, rsp_live, pop;
   assign imem_req_valid = !redirect_valid && ({1'b0, count} + {1'b0, drop} < (CW + 1)'(DEPTH));
   assign imem_req_addr = pc;
   assign accept = imem_req_valid && imem_req_ready;
   // responses with nothing live outstanding are protocol violations and are ignored
   assign rsp_live = imem_rsp_valid && drop == '0 && pend != '0 && !redirect_valid;
   assign pop = out_valid && out_ready;
   assign occupancy = count;
   fetch_queue #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) queue (
      .clk(clk),
      .rst(rst),
      .reserve(accept),
      .reserve_pc(pc),
      .fill(rsp_live),
      .fill_data(imem_rsp_data),
      .pop(pop),
      .flush(redirect_valid),
      .head_valid(out_valid),
      .head_instr(out_instr),
      .head_pc(out_pc),
      .count(count)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         pc <= RESET_ADDR;
         drop <= '0;
         pend <= '0;
      end else if (redirect_valid) begin
         pc <= redirect_addr;
         pend <= '0;
         drop <= drop + pend - CW'(imem_rsp_valid && (drop != '0 || pend != '0));
      end else begin
         if (accept) pc <= pc + ADDR_W'(1);
         pend <= pend + CW'(accept) - CW'(rsp_live);
         if (imem_rsp_valid && drop != '0) drop <= drop - CW'(1);
      end
endmodule
